atm_auth_ctrl: RTL and testbench

Session/authentication controller feeding the balance-display stage. Accepts a card ID and PIN, checks the PIN against a per-account PIN ROM, counts failed attempts with per-account lockout and enforces an inactivity timeout. On an authenticated balance request it drives a stable ID and a ShowBalance level to the downstream balance viewer.

---
 rtl/atm_pkg.sv | 38 +++
 rtl/atm_pin_rom.sv | 29 ++
 rtl/atm_auth_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_atm_auth_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared constants, FSM state type and the account PIN table for the ATM session controller.
// PIN_TABLE is the accounts_pinRAM.mem image: entry i is the PIN of account i.
package atm_pkg;

    localparam int NUM_ACCOUNTS    = 5;
    localparam int ID_W            = 4;
    localparam int PIN_W           = 8;
    localparam int DEF_MAX_TRIES   = 3;
    localparam int DEF_TIMEOUT_CYC = 64;
    localparam int DEF_SHOW_CYC    = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PIN,
        CHECK,
        AUTH,
        SHOW
    } state_t;

    localparam logic [NUM_ACCOUNTS-1:0][PIN_W-1:0] PIN_TABLE = {
        8'h07,  // account 4
        8'hC3,  // account 3
        8'h5A,  // account 2
        8'h22,  // account 1
        8'h11   // account 0
    };

    // One-hot account select; all-zero for IDs outside the account range.
    function automatic logic [NUM_ACCOUNTS-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_ACCOUNTS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (id == ID_W'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/atm_pin_rom.sv
// Synchronous-read PIN table, one entry per account, one cycle of read latency.
// Out-of-range addresses read as zero.
module atm_pin_rom
    import atm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [ID_W-1:0]  addr_i,
    output logic [PIN_W-1:0] data_o
);

    logic [PIN_W-1:0] word_d;
    logic [PIN_W-1:0] data_q;

    always_comb begin
        word_d = '0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (addr_i == ID_W'(i)) word_d = PIN_TABLE[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= word_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/atm_auth_ctrl.sv
// ATM session controller: card check, PIN verification with per-account lockout,
// inactivity timeout and timed ShowBalance. Define ATM_ADMIN_UNLOCK_EN for the admin unlock port.
//
// state    | meaning
// IDLE     | no session; card_valid checked against range and lock bitmap
// WAIT_PIN | card accepted, waiting for pin_valid, idle timer running
// CHECK    | PIN ROM word available, compare against registered pin
// AUTH     | authenticated, waiting for op_balance, idle timer running
// SHOW     | ShowBalance asserted for SHOW_CYC cycles
module atm_auth_ctrl
    import atm_pkg::*;
#(
    parameter int MAX_TRIES   = DEF_MAX_TRIES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SHOW_CYC    = DEF_SHOW_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             card_valid,
    input  logic [ID_W-1:0]  card_id,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    input  logic             op_balance,
    input  logic             logout,
`ifdef ATM_ADMIN_UNLOCK_EN
    input  logic             admin_unlock,
    input  logic [ID_W-1:0]  unlock_id,
`endif
    output logic [ID_W-1:0]  ID,
    output logic             ShowBalance,
    output logic             card_reject,
    output logic             auth_ok,
    output logic             auth_fail,
    output logic             lock_evt,
    output logic             session_active
);

    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYC);
    localparam int SHOW_W  = $clog2(SHOW_CYC + 1);

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [PIN_W-1:0]        pin_q, pin_d;
    logic [TRIES_W-1:0]      tries_q, tries_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [SHOW_W-1:0]       show_cnt_q, show_cnt_d;
    logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;
    logic                    show_q, show_d;
    logic                    reject_q, reject_d;
    logic                    ok_q, ok_d;
    logic                    fail_q, fail_d;
    logic                    lockevt_q, lockevt_d;
    logic                    sess_q, sess_d;

    logic [PIN_W-1:0]        rom_pin;
    logic                    timeout;
    logic [TIMER_W-1:0]      timer_inc;
    logic                    card_ok;

    // The ROM address is the latched ID, so the word is ready by the time CHECK is entered.
    atm_pin_rom u_pin_rom (
        .clk    (clk),
        .reset  (reset),
        .addr_i (id_q),
        .data_o (rom_pin)
    );

    assign timeout   = (timer_q == TIMER_W'(TIMEOUT_CYC - 1));
    assign timer_inc = timeout ? timer_q : timer_q + 1'b1;
    assign card_ok   = (|id_onehot(card_id)) && ~(|(lock_q & id_onehot(card_id)));

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        pin_d      = pin_q;
        tries_d    = tries_q;
        timer_d    = timer_q;
        show_cnt_d = show_cnt_q;
        lock_d     = lock_q;
        reject_d   = 1'b0;
        ok_d       = 1'b0;
        fail_d     = 1'b0;
        lockevt_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (card_valid) begin
                    if (card_ok) begin
                        state_d = WAIT_PIN;
                        id_d    = card_id;
                        tries_d = '0;
                        timer_d = '0;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            WAIT_PIN: begin
                if (logout || timeout) begin
                    state_d = IDLE;
                end else if (pin_valid) begin
                    state_d = CHECK;
                    pin_d   = pin;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            CHECK: begin
                timer_d = '0;
                if (logout) begin
                    state_d = IDLE;
                end else if (rom_pin == pin_q) begin
                    state_d = AUTH;
                    ok_d    = 1'b1;
                end else if (tries_q == TRIES_W'(MAX_TRIES - 1)) begin
                    state_d   = IDLE;
                    lock_d    = lock_q | id_onehot(id_q);
                    lockevt_d = 1'b1;
                end else begin
                    state_d = WAIT_PIN;
                    tries_d = tries_q + 1'b1;
                    fail_d  = 1'b1;
                end
            end
            AUTH: begin
                if (logout || timeout) begin
                    state_d = IDLE;
                end else if (op_balance) begin
                    state_d    = SHOW;
                    show_cnt_d = '0;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            SHOW: begin
                if (logout) begin
                    state_d = IDLE;
                end else if (show_cnt_q == SHOW_W'(SHOW_CYC - 1)) begin
                    state_d = AUTH;
                    timer_d = '0;
                end else begin
                    show_cnt_d = show_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ATM_ADMIN_UNLOCK_EN
        // Applied after any lock set so a coincident unlock of the same account wins.
        if (admin_unlock) lock_d = lock_d & ~id_onehot(unlock_id);
`endif

        show_d = (state_d == SHOW);
        sess_d = (state_d == AUTH) || (state_d == SHOW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            id_q       <= '0;
            pin_q      <= '0;
            tries_q    <= '0;
            timer_q    <= '0;
            show_cnt_q <= '0;
            lock_q     <= '0;
            show_q     <= 1'b0;
            reject_q   <= 1'b0;
            ok_q       <= 1'b0;
            fail_q     <= 1'b0;
            lockevt_q  <= 1'b0;
            sess_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            pin_q      <= pin_d;
            tries_q    <= tries_d;
            timer_q    <= timer_d;
            show_cnt_q <= show_cnt_d;
            lock_q     <= lock_d;
            show_q     <= show_d;
            reject_q   <= reject_d;
            ok_q       <= ok_d;
            fail_q     <= fail_d;
            lockevt_q  <= lockevt_d;
            sess_q     <= sess_d;
        end
    end

    assign ID             = id_q;
    assign ShowBalance    = show_q;
    assign card_reject    = reject_q;
    assign auth_ok        = ok_q;
    assign auth_fail      = fail_q;
    assign lock_evt       = lockevt_q;
    assign session_active = sess_q;

endmodule

// File: tb/tb_atm_auth_ctrl.sv
// Self-checking bench for atm_auth_ctrl: vector table, directed corner sequences and random
// stimulus against a session-level reference model. Define ATM_ADMIN_UNLOCK_EN to cover unlock.
module tb_atm_auth_ctrl;

    localparam int N_ACCT  = 5;
    localparam int MAXT    = 3;
    localparam int TOUT    = 64;
    localparam int SHOWN   = 8;
    localparam logic [7:0] ACCT_PIN [N_ACCT] = '{8'h11, 8'h22, 8'h5A, 8'hC3, 8'h07};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       card_valid = 1'b0;
    logic [3:0] card_id = '0;
    logic       pin_valid = 1'b0;
    logic [7:0] pin = '0;
    logic       op_balance = 1'b0;
    logic       logout = 1'b0;
`ifdef ATM_ADMIN_UNLOCK_EN
    logic       admin_unlock = 1'b0;
    logic [3:0] unlock_id = '0;
`endif
    logic [3:0] ID;
    logic       ShowBalance, card_reject, auth_ok, auth_fail, lock_evt, session_active;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    atm_auth_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .card_valid     (card_valid),
        .card_id        (card_id),
        .pin_valid      (pin_valid),
        .pin            (pin),
        .op_balance     (op_balance),
        .logout         (logout),
`ifdef ATM_ADMIN_UNLOCK_EN
        .admin_unlock   (admin_unlock),
        .unlock_id      (unlock_id),
`endif
        .ID             (ID),
        .ShowBalance    (ShowBalance),
        .card_reject    (card_reject),
        .auth_ok        (auth_ok),
        .auth_fail      (auth_fail),
        .lock_evt       (lock_evt),
        .session_active (session_active)
    );

    // Reference model: a session is a card in the slot, optionally a PIN under check,
    // optionally authenticated, optionally a display countdown.
    bit         m_card, m_checking, m_authed;
    int         m_show_left, m_idle, m_tries, m_id;
    bit         m_lock [N_ACCT];
    logic [7:0] m_pend;
    bit         m_rej, m_ok, m_fail, m_lockevt;

    task automatic model_reset();
        m_card = 0; m_checking = 0; m_authed = 0;
        m_show_left = 0; m_idle = 0; m_tries = 0; m_id = 0; m_pend = '0;
        m_rej = 0; m_ok = 0; m_fail = 0; m_lockevt = 0;
        for (int i = 0; i < N_ACCT; i++) m_lock[i] = 0;
    endtask

    task automatic end_session();
        m_card = 0; m_authed = 0; m_checking = 0; m_show_left = 0;
    endtask

    task automatic model_step(input bit cv, input int cid, input bit pv, input logic [7:0] p,
                              input bit ob, input bit lo, input bit au, input int uid);
        m_rej = 0; m_ok = 0; m_fail = 0; m_lockevt = 0;
        if (!m_card) begin
            if (cv) begin
                if (cid < N_ACCT && !m_lock[cid]) begin
                    m_card = 1; m_id = cid; m_tries = 0; m_idle = 0;
                    m_authed = 0; m_checking = 0; m_show_left = 0;
                end else begin
                    m_rej = 1;
                end
            end
        end else if (lo) begin
            end_session();
        end else if (m_checking) begin
            m_checking = 0;
            m_idle = 0;
            if (m_pend == ACCT_PIN[m_id]) begin
                m_authed = 1; m_ok = 1;
            end else if (m_tries + 1 == MAXT) begin
                m_lock[m_id] = 1; m_lockevt = 1;
                end_session();
            end else begin
                m_tries++; m_fail = 1;
            end
        end else if (m_show_left > 0) begin
            m_show_left--;
            if (m_show_left == 0) m_idle = 0;
        end else if (m_idle == TOUT - 1) begin
            end_session();
        end else if (!m_authed && pv) begin
            m_pend = p; m_checking = 1; m_idle = 0;
        end else if (m_authed && ob) begin
            m_show_left = SHOWN;
        end else begin
            m_idle++;
        end
        if (au && uid < N_ACCT) m_lock[uid] = 0;
    endtask

    function automatic logic [9:0] dut_vec();
        return {ID, ShowBalance, card_reject, auth_ok, auth_fail, lock_evt, session_active};
    endfunction

    function automatic logic [9:0] model_vec();
        return {4'(m_id), (m_show_left > 0), m_rej, m_ok, m_fail, m_lockevt, (m_card && m_authed)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        bit cv = card_valid;
        int cid = int'(card_id);
        bit pv = pin_valid;
        logic [7:0] p = pin;
        bit ob = op_balance;
        bit lo = logout;
        bit au = 1'b0;
        int uid = 0;
`ifdef ATM_ADMIN_UNLOCK_EN
        au = admin_unlock;
        uid = int'(unlock_id);
`endif
        @(posedge clk);
        #1;
        model_step(cv, cid, pv, p, ob, lo, au, uid);
        check("model", dut_vec(), model_vec());
        card_valid = 0; pin_valid = 0; op_balance = 0; logout = 0;
`ifdef ATM_ADMIN_UNLOCK_EN
        admin_unlock = 0;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("reset_outputs", dut_vec(), 10'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive_card(input logic [3:0] id);
        card_valid = 1; card_id = id;
        tick();
    endtask

    // PIN accepted on the first edge, result visible after the second.
    task automatic drive_pin(input logic [7:0] p);
        pin_valid = 1; pin = p;
        tick();
        tick();
    endtask

    typedef struct {
        bit         cv;
        logic [3:0] cid;
        bit         pv;
        logic [7:0] pin;
        bit         ob;
        bit         lo;
        logic [9:0] exp;   // {ID, show, reject, ok, fail, lock_evt, session}
    } vec_t;

    vec_t vt [12];

    initial begin
        int hi, cnt;
        bit idbad;

        vt[0]  = '{1, 4'd7, 0, 8'h00, 0, 0, {4'd0, 6'b010000}};
        vt[1]  = '{0, 4'd0, 0, 8'h00, 0, 0, {4'd0, 6'b000000}};
        vt[2]  = '{1, 4'd2, 0, 8'h00, 0, 0, {4'd2, 6'b000000}};
        vt[3]  = '{0, 4'd0, 1, 8'h00, 0, 0, {4'd2, 6'b000000}};
        vt[4]  = '{0, 4'd0, 0, 8'h00, 0, 0, {4'd2, 6'b000100}};
        vt[5]  = '{0, 4'd0, 1, 8'h5A, 0, 0, {4'd2, 6'b000000}};
        vt[6]  = '{0, 4'd0, 0, 8'h00, 0, 0, {4'd2, 6'b001001}};
        vt[7]  = '{0, 4'd0, 0, 8'h00, 1, 0, {4'd2, 6'b100001}};
        vt[8]  = '{1, 4'd1, 0, 8'h00, 0, 0, {4'd2, 6'b100001}};
        vt[9]  = '{0, 4'd0, 0, 8'h00, 0, 1, {4'd2, 6'b000000}};
        vt[10] = '{1, 4'd2, 0, 8'h00, 0, 0, {4'd2, 6'b000000}};
        vt[11] = '{0, 4'd0, 0, 8'h00, 0, 1, {4'd2, 6'b000000}};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", dut_vec(), 10'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            card_valid = vt[i].cv; card_id = vt[i].cid;
            pin_valid = vt[i].pv; pin = vt[i].pin;
            op_balance = vt[i].ob; logout = vt[i].lo;
            tick();
            check($sformatf("vec%0d", i), dut_vec(), vt[i].exp);
        end

        // ShowBalance length, ID stability, op_balance ignored during SHOW
        do_reset();
        drive_card(4'd2);
        drive_pin(8'h5A);
        check("auth_ok", auth_ok, 1);
        op_balance = 1;
        tick();
        hi = 0; idbad = 0;
        for (int k = 0; k < 20 && ShowBalance; k++) begin
            hi++;
            if (ID !== 4'd2) idbad = 1;
            if (k == 3) op_balance = 1;
            tick();
        end
        check("show_len", hi, SHOWN);
        check("show_id_stable", idbad, 0);
        check("sess_after_show", session_active, 1);
        op_balance = 1;
        tick();
        check("show_again", ShowBalance, 1);

        // lockout after three wrong PINs, other accounts unaffected
        do_reset();
        drive_card(4'd2);
        drive_pin(8'h00);
        check("fail1", auth_fail, 1);
        drive_pin(8'h01);
        check("fail2", auth_fail, 1);
        drive_pin(8'h02);
        check("lock_evt", lock_evt, 1);
        check("lock_sess", session_active, 0);
        drive_card(4'd2);
        check("locked_reject", card_reject, 1);
        drive_card(4'd1);
        check("other_accept", {card_reject, ID}, {1'b0, 4'd1});
        drive_pin(8'h22);
        check("other_auth", auth_ok, 1);

        // out-of-range card leaves ID alone; reject is a single-cycle pulse
        logout = 1;
        tick();
        drive_card(4'd7);
        check("range_reject", {card_reject, ID}, {1'b1, 4'd1});
        tick();
        check("reject_pulse", card_reject, 0);

        // AUTH timeout
        do_reset();
        drive_card(4'd3);
        drive_pin(8'hC3);
        cnt = 0;
        while (session_active && cnt < 100) begin
            tick();
            cnt++;
        end
        check("auth_timeout_cycles", cnt, TOUT);
        op_balance = 1;
        tick();
        check("balance_after_timeout", {ShowBalance, session_active}, 2'b00);

        // pin_valid coincident with WAIT_PIN timeout loses
        drive_card(4'd3);
        repeat (TOUT - 1) tick();
        pin_valid = 1; pin = 8'hC3;
        tick();
        tick();
        check("pin_at_timeout", {auth_ok, session_active}, 2'b00);

        // logout in third SHOW cycle
        do_reset();
        drive_card(4'd4);
        drive_pin(8'h07);
        op_balance = 1;
        tick();
        tick();
        tick();
        check("show_cycle3", ShowBalance, 1);
        logout = 1;
        tick();
        check("logout_show", {ShowBalance, session_active}, 2'b00);
        op_balance = 1;
        tick();
        check("idle_ignores_balance", ShowBalance, 0);

        // reset mid-SHOW clears outputs immediately and the lock bitmap
        drive_card(4'd3);
        drive_pin(8'h00);
        drive_pin(8'h00);
        drive_pin(8'h00);
        check("lock3", lock_evt, 1);
        drive_card(4'd1);
        drive_pin(8'h22);
        op_balance = 1;
        tick();
        check("pre_reset_show", ShowBalance, 1);
        do_reset();
        drive_card(4'd3);
        check("lock_cleared", {card_reject, ID}, {1'b0, 4'd3});

`ifdef ATM_ADMIN_UNLOCK_EN
        do_reset();
        drive_card(4'd2);
        drive_pin(8'h00);
        drive_pin(8'h00);
        drive_pin(8'h00);
        drive_card(4'd2);
        check("admin_locked", card_reject, 1);
        admin_unlock = 1; unlock_id = 4'd2;
        tick();
        drive_card(4'd2);
        check("admin_unlocked", {card_reject, ID}, {1'b0, 4'd2});
`endif

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 499) begin
                do_reset();
            end else begin
                card_valid = ($urandom_range(0, 5) == 0);
                card_id    = 4'($urandom_range(0, 7));
                pin_valid  = ($urandom_range(0, 4) == 0);
                pin        = $urandom_range(0, 1) ? ACCT_PIN[m_id] : 8'($urandom);
                op_balance = ($urandom_range(0, 5) == 0);
                logout     = ($urandom_range(0, 49) == 0);
`ifdef ATM_ADMIN_UNLOCK_EN
                admin_unlock = ($urandom_range(0, 39) == 0);
                unlock_id    = 4'($urandom_range(0, 7));
`endif
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
